// File: rtl/video_timing.sv
// Raster timing generator: pixel-enable divider, H/V counters, registered blank/sync,
// delayed composite blank for the palette, and vertical-blank / raster-line interrupts.
module video_timing #(
  parameter int H_VISIBLE = 384,
  parameter int H_TOTAL   = 512,
  parameter int HS_START  = 416,
  parameter int HS_END    = 448,
  parameter int V_VISIBLE = 256,
  parameter int V_TOTAL   = 284,
  parameter int VS_START  = 264,
  parameter int VS_END    = 268,
  parameter int PAL_DELAY = 1
) (
  input  logic       CLK_32M,
  input  logic       reset,
  input  logic [8:0] RASTER_LINE,
  output logic       CE_PIX,
  output logic [8:0] HCNT,
  output logic [8:0] VCNT,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       CBLK_N,
  output logic       VBL_INT,
  output logic       RASTER_INT
);

  // Ten-bit constants so that limits equal to 512 still compare correctly.
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_ON  = 10'(HS_START);
  localparam logic [9:0] HS_OFF = 10'(HS_END);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_ON  = 10'(VS_START);
  localparam logic [9:0] VS_OFF = 10'(VS_END);

  logic [1:0] div;
  logic [8:0] hcnt_next;
  logic [8:0] vcnt_next;
  logic       h_wrap;
  logic       blank;

  assign CE_PIX = (div == 2'd3);
  assign blank  = HBLANK | VBLANK;

  always_comb begin
    h_wrap    = ({1'b0, HCNT} == H_LAST);
    hcnt_next = h_wrap ? 9'd0 : HCNT + 9'd1;
    vcnt_next = VCNT;
    if (h_wrap)
      vcnt_next = ({1'b0, VCNT} == V_LAST) ? 9'd0 : VCNT + 9'd1;
  end

  // Flags are computed from the next counter values so they change on the same edge.
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      div        <= 2'd0;
      HCNT       <= 9'd0;
      VCNT       <= 9'd0;
      HBLANK     <= 1'b0;
      VBLANK     <= 1'b0;
      HSYNC      <= 1'b0;
      VSYNC      <= 1'b0;
      VBL_INT    <= 1'b0;
      RASTER_INT <= 1'b0;
    end else begin
      div        <= div + 2'd1;
      VBL_INT    <= 1'b0;
      RASTER_INT <= 1'b0;
      if (CE_PIX) begin
        HCNT       <= hcnt_next;
        VCNT       <= vcnt_next;
        HBLANK     <= ({1'b0, hcnt_next} >= H_VIS);
        VBLANK     <= ({1'b0, vcnt_next} >= V_VIS);
        HSYNC      <= ({1'b0, hcnt_next} >= HS_ON) && ({1'b0, hcnt_next} < HS_OFF);
        VSYNC      <= ({1'b0, vcnt_next} >= VS_ON) && ({1'b0, vcnt_next} < VS_OFF);
        VBL_INT    <= h_wrap && ({1'b0, vcnt_next} == V_VIS);
        RASTER_INT <= h_wrap && (vcnt_next == RASTER_LINE);
      end
    end
  end

  generate
    if (PAL_DELAY == 0) begin : g_no_delay
      assign CBLK_N = ~blank;
    end else begin : g_delay
      logic [PAL_DELAY-1:0] stage;

      always_ff @(posedge CLK_32M) begin
        if (reset) begin
          stage <= '1;
        end else if (CE_PIX) begin
          stage[0] <= ~blank;
          for (int i = 1; i < PAL_DELAY; i++)
            stage[i] <= stage[i-1];
        end
      end

      assign CBLK_N = stage[PAL_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing using a shrunken raster so whole frames fit in a short run;
// a closed-form cycle model supplies expected outputs for every clock after reset release.
module tb_video_timing;

  localparam int HV  = 12;
  localparam int HT  = 20;
  localparam int HSS = 14;
  localparam int HSE = 16;
  localparam int VV  = 8;
  localparam int VT  = 12;
  localparam int VSS = 9;
  localparam int VSE = 10;
  localparam int PD  = 1;

  logic       clk32m;
  logic       reset;
  logic [8:0] rasterLine;
  logic       cePix;
  logic [8:0] hcnt;
  logic [8:0] vcnt;
  logic       hblank;
  logic       vblank;
  logic       hsync;
  logic       vsync;
  logic       cblkN;
  logic       vblInt;
  logic       rasterInt;

  int compared;
  int mismatched;
  int k;
  int vblCount;
  int rasCount;
  int bothCount;

  video_timing #(
    .H_VISIBLE(HV), .H_TOTAL(HT), .HS_START(HSS), .HS_END(HSE),
    .V_VISIBLE(VV), .V_TOTAL(VT), .VS_START(VSS), .VS_END(VSE),
    .PAL_DELAY(PD)
  ) dut (
    .CLK_32M(clk32m),
    .reset(reset),
    .RASTER_LINE(rasterLine),
    .CE_PIX(cePix),
    .HCNT(hcnt),
    .VCNT(vcnt),
    .HBLANK(hblank),
    .VBLANK(vblank),
    .HSYNC(hsync),
    .VSYNC(vsync),
    .CBLK_N(cblkN),
    .VBL_INT(vblInt),
    .RASTER_INT(rasterInt)
  );

  initial begin
    clk32m = 1'b0;
    forever #5 clk32m = ~clk32m;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s k=%0d observed=%0d expected=%0d", tag, k, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [8:0] line);
    reset      = rst;
    rasterLine = line;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".ce"},     cePix,     0);
    checkOutput({tag, ".hcnt"},   hcnt,      0);
    checkOutput({tag, ".vcnt"},   vcnt,      0);
    checkOutput({tag, ".hblank"}, hblank,    0);
    checkOutput({tag, ".vblank"}, vblank,    0);
    checkOutput({tag, ".hsync"},  hsync,     0);
    checkOutput({tag, ".vsync"},  vsync,     0);
    checkOutput({tag, ".cblkN"},  cblkN,     1);
    checkOutput({tag, ".vblInt"}, vblInt,    0);
    checkOutput({tag, ".rasInt"}, rasterInt, 0);
  endtask

  // k counts edges since reset release; p is the number of pixel-enable edges seen so far.
  task automatic checkModel();
    int p, h, v, hp, vp;
    logic expCblk, pulseEdge;
    p = k / 4;
    h = p % HT;
    v = (p / HT) % VT;
    if (p == 0) begin
      expCblk = 1'b1;
    end else begin
      hp = (p - 1) % HT;
      vp = ((p - 1) / HT) % VT;
      expCblk = !((hp >= HV) || (vp >= VV));
    end
    pulseEdge = (k % 4 == 0) && (p > 0) && (h == 0);
    checkOutput("ce",     cePix,  (k % 4 == 3));
    checkOutput("hcnt",   hcnt,   h);
    checkOutput("vcnt",   vcnt,   v);
    checkOutput("hblank", hblank, (h >= HV));
    checkOutput("vblank", vblank, (v >= VV));
    checkOutput("hsync",  hsync,  (h >= HSS) && (h < HSE));
    checkOutput("vsync",  vsync,  (v >= VSS) && (v < VSE));
    checkOutput("cblkN",  cblkN,  expCblk);
    checkOutput("vblInt", vblInt, pulseEdge && (v == VV));
    checkOutput("rasInt", rasterInt, pulseEdge && (v == int'(rasterLine)));
    vblCount  += int'(vblInt);
    rasCount  += int'(rasterInt);
    bothCount += int'(vblInt && rasterInt);
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk32m);
      #1;
      k++;
      checkModel();
    end
  endtask

  task automatic clearCounts();
    vblCount  = 0;
    rasCount  = 0;
    bothCount = 0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    k          = 0;
    clearCounts();

    applyStimulus(1'b1, 9'd5);
    repeat (3) begin
      @(posedge clk32m);
      #1;
      checkReset("reset");
    end

    // Release; first pixel enable lands in cycle 3, HCNT becomes 1 on edge 4.
    applyStimulus(1'b0, 9'd5);
    k = 0;
    runCycles(3);
    checkOutput("firstCe", cePix, 1);
    checkOutput("firstCeHcnt", hcnt, 0);
    runCycles(1);
    checkOutput("afterFirstCeHcnt", hcnt, 1);

    // One full frame of 12 x 20 x 4 = 960 clocks with raster line 5.
    runCycles(960 - k);
    checkOutput("frame1Vbl", vblCount, 1);
    checkOutput("frame1Ras", rasCount, 1);
    checkOutput("frameWrapH", hcnt, 0);
    checkOutput("frameWrapV", vcnt, 0);

    // Move the raster line backwards mid-frame: no pulse until next frame's line 3.
    runCycles(1452 - k);
    checkOutput("midLine", vcnt, 6);
    applyStimulus(1'b0, 9'd3);
    clearCounts();
    runCycles(1920 - k);
    checkOutput("movedRasRestOfFrame", rasCount, 0);
    clearCounts();
    runCycles(2400 - k);
    checkOutput("movedRasNextFrame", rasCount, 1);

    // Raster line at the first blank line coincides with the vertical-blank pulse.
    applyStimulus(1'b0, 9'(VV));
    clearCounts();
    runCycles(2880 - k);
    checkOutput("coincVbl", vblCount, 1);
    checkOutput("coincRas", rasCount, 1);
    checkOutput("coincBoth", bothCount, 1);

    // Raster line beyond the frame never fires.
    applyStimulus(1'b0, 9'd300);
    clearCounts();
    runCycles(3840 - k);
    checkOutput("outOfRangeRas", rasCount, 0);
    checkOutput("outOfRangeVbl", vblCount, 1);

    // One-clock reset mid-frame at line 6, pixel 10.
    runCycles(4360 - k);
    checkOutput("preResetV", vcnt, 6);
    checkOutput("preResetH", hcnt, 10);
    applyStimulus(1'b1, 9'd300);
    @(posedge clk32m);
    #1;
    checkReset("midReset");
    applyStimulus(1'b0, 9'd5);
    k = 0;
    clearCounts();
    runCycles(964);
    checkOutput("restartVbl", vblCount, 1);
    checkOutput("restartRas", rasCount, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
